// File: rtl/register_file_port_sequencer_pkg.sv
// Shared types and default sizes for the register-file port sequencer.
// The FSM state encoding lives here so the sequencer and its users agree on it.
package register_file_port_sequencer_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  typedef enum logic [2:0] {
    IDLE,
    RS1,
    RS2,
    HOLD,
    WB
  } rfps_state_e;

endpackage

// File: rtl/d_flip_flop.sv
// Enabled D register with asynchronous active-high clear.
// This is the shared storage primitive for the datapath registers.
module d_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/register_file_port_sequencer.sv
// Serialises decode operand fetches and execute writebacks onto the single
// cs/we/addr port of the integer register file; x0 never costs a port cycle.
module register_file_port_sequencer #(
  parameter int XLEN = register_file_port_sequencer_pkg::XLEN,
  parameter int AW   = register_file_port_sequencer_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [AW-1:0]   req_rd,
  input  logic            req_use_rs1,
  input  logic            req_use_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [AW-1:0]   out_rd,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_cs,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_wr_data,
  input  logic [XLEN-1:0] rf_rd_data
);

  import register_file_port_sequencer_pkg::*;

  rfps_state_e state, state_nxt;

  logic            req_fire;
  logic            wb_load;
  logic            eff1, eff2;
  logic [AW-1:0]   rs1_q, rs2_q, wb_rd_q;
  logic            eff2_q;
  logic [XLEN-1:0] wb_data_q;
  logic            op1_en, op2_en;
  logic [XLEN-1:0] op1_d, op2_d;

  // A source is only fetched when it is needed and is not the hard-wired x0.
  assign eff1 = req_use_rs1 && (req_rs1 != '0);
  assign eff2 = req_use_rs2 && (req_rs2 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    req_fire   = 1'b0;
    wb_ready   = 1'b0;
    wb_load    = 1'b0;
    out_valid  = 1'b0;
    rf_cs      = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_wr_data = '0;
    case (state)
      IDLE: begin
        wb_ready  = 1'b1;
        req_ready = !wb_valid && !flush;
        req_fire  = req_valid && req_ready;
        if (wb_valid) begin
          // Writes to x0 are accepted and silently dropped.
          if (wb_rd != '0) begin
            wb_load   = 1'b1;
            state_nxt = WB;
          end
        end else if (req_fire) begin
          state_nxt = eff1 ? RS1 : (eff2 ? RS2 : HOLD);
        end
      end
      RS1: begin
        rf_cs     = 1'b1;
        rf_addr   = rs1_q;
        state_nxt = flush ? IDLE : (eff2_q ? RS2 : HOLD);
      end
      RS2: begin
        rf_cs     = 1'b1;
        rf_addr   = rs2_q;
        state_nxt = flush ? IDLE : HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_nxt = IDLE;
      end
      WB: begin
        // flush is deliberately ignored: the write always lands.
        rf_cs      = 1'b1;
        rf_we      = 1'b1;
        rf_addr    = wb_rd_q;
        rf_wr_data = wb_data_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept clears the operands so skipped sources read as zero.
  assign op1_en = req_fire || (state == RS1 && !flush);
  assign op2_en = req_fire || (state == RS2 && !flush);
  assign op1_d  = (state == RS1) ? rf_rd_data : '0;
  assign op2_d  = (state == RS2) ? rf_rd_data : '0;

  d_flip_flop #(.WIDTH(2*AW+1)) u_req_q (
    .clk (clk),
    .rst (rst),
    .en  (req_fire),
    .d   ({req_rs1, req_rs2, eff2}),
    .q   ({rs1_q, rs2_q, eff2_q})
  );

  d_flip_flop #(.WIDTH(AW)) u_rd_q (
    .clk (clk),
    .rst (rst),
    .en  (req_fire),
    .d   (req_rd),
    .q   (out_rd)
  );

  d_flip_flop #(.WIDTH(XLEN)) u_op1_q (
    .clk (clk),
    .rst (rst),
    .en  (op1_en),
    .d   (op1_d),
    .q   (out_op1)
  );

  d_flip_flop #(.WIDTH(XLEN)) u_op2_q (
    .clk (clk),
    .rst (rst),
    .en  (op2_en),
    .d   (op2_d),
    .q   (out_op2)
  );

  d_flip_flop #(.WIDTH(AW+XLEN)) u_wb_q (
    .clk (clk),
    .rst (rst),
    .en  (wb_load),
    .d   ({wb_rd, wb_data}),
    .q   ({wb_rd_q, wb_data_q})
  );

endmodule

// File: tb/tb_register_file_port_sequencer.sv
// Directed bench for register_file_port_sequencer with a behavioural
// register file attached to its port.
module tb_register_file_port_sequencer;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_rs1, req_rs2, req_rd;
  logic            req_use_rs1, req_use_rs2;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_op1, out_op2;
  logic [AW-1:0]   out_rd;
  logic            wb_valid, wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            rf_cs, rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XLEN-1:0] rf_wr_data, rf_rd_data;

  logic [XLEN-1:0] mem [32];
  int              cs_count;
  int              total, bad;
  int              cs_before;

  always #5 clk = ~clk;

  register_file_port_sequencer #(.XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .req_use_rs1 (req_use_rs1),
    .req_use_rs2 (req_use_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .rf_cs       (rf_cs),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd_data  (rf_rd_data)
  );

  // Behavioural register file: combinational read, write on the clock edge.
  assign rf_rd_data = mem[rf_addr];

  always @(posedge clk) begin
    if (rf_cs && rf_we) mem[rf_addr] <= rf_wr_data;
    if (rf_cs) cs_count <= cs_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    #1;
    check("wb_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("wb_port_cs", rf_cs, 1);
    check("wb_port_we", rf_we, 1);
    check("wb_port_addr", rf_addr, rd);
    check("wb_port_data", rf_wr_data, data);
    tick();
  endtask

  // Issues one request and checks the port sequence, latency and operands.
  task automatic fetch(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] d,
                       input logic u1, input logic u2, input int lat, input int hold,
                       input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    req_rs1 = a1; req_rs2 = a2; req_rd = d;
    req_use_rs1 = u1; req_use_rs2 = u2;
    req_valid = 1'b1;
    #1;
    check("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    for (int i = 1; i < lat; i++) begin
      check("out_valid_early", out_valid, 0);
      check("fetch_cs", rf_cs, 1);
      check("fetch_we", rf_we, 0);
      if (i == 1 && lat == 3) check("fetch_addr_rs1", rf_addr, a1);
      else if (i == 2)        check("fetch_addr_rs2", rf_addr, a2);
      tick();
      #1;
    end
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", out_valid, 1);
      check("out_op1", out_op1, e1);
      check("out_op2", out_op2, e2);
      check("out_rd", out_rd, d);
      check("hold_cs", rf_cs, 0);
      if (h < hold) begin
        tick();
        #1;
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    total = 0; bad = 0; cs_count = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    req_use_rs1 = 1'b0; req_use_rs2 = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_op1", out_op1, 0);
    check("rst_op2", out_op2, 0);
    check("rst_rd", out_rd, 0);
    check("rst_cs", rf_cs, 0);
    check("rst_we", rf_we, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_wdata", rf_wr_data, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_wb_ready", wb_ready, 1);
    wb_valid = 1'b1;
    #1;
    check("rst_req_ready_wb", req_ready, 0);
    wb_valid = 1'b0;
    #8 rst = 1'b0;
    tick();

    // Single-operand read after a write.
    wb_write(5'd5, 64'hDEADBEEF00000001);
    cs_before = cs_count;
    fetch(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 2, 0, 64'hDEADBEEF00000001, 64'h0);
    check("one_cs_pulse", cs_count - cs_before, 1);

    // Two operands held for 4 cycles of back-pressure.
    wb_write(5'd3, 64'h11);
    wb_write(5'd7, 64'h22);
    fetch(5'd3, 5'd7, 5'd9, 1'b1, 1'b1, 3, 4, 64'h11, 64'h22);

    // Writeback wins against a simultaneous request.
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h55;
    req_valid = 1'b1; req_rs1 = 5'd4; req_use_rs1 = 1'b1; req_use_rs2 = 1'b0;
    #1;
    check("prio_req_ready", req_ready, 0);
    check("prio_wb_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("prio_we", rf_we, 1);
    check("prio_wdata", rf_wr_data, 64'h55);
    check("prio_req_ready_wb", req_ready, 0);
    tick();
    req_valid = 1'b0;
    fetch(5'd4, 5'd0, 5'd2, 1'b1, 1'b0, 2, 0, 64'h55, 64'h0);

    // x0 write dropped, x0 reads skip the port and clear operands.
    cs_before = cs_count;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
    #1;
    check("x0_wb_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("x0_wb_cs", rf_cs, 0);
    fetch(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1, 0, 64'h0, 64'h0);
    check("x0_no_port", cs_count - cs_before, 0);
    check("x0_mem", mem[0], 64'h0);

    // Flush in RS2 aborts the fetch.
    req_rs1 = 5'd3; req_rs2 = 5'd7; req_rd = 5'd4;
    req_use_rs1 = 1'b1; req_use_rs2 = 1'b1;
    req_valid = 1'b1;
    #1;
    tick();
    req_valid = 1'b0;
    #1;
    check("fl_rs1_addr", rf_addr, 3);
    tick();
    flush = 1'b1;
    #1;
    check("fl_rs2_addr", rf_addr, 7);
    tick();
    flush = 1'b0;
    #1;
    check("fl_idle_ready", req_ready, 1);
    check("fl_idle_cs", rf_cs, 0);
    check("fl_no_valid", out_valid, 0);
    tick();
    #1;
    check("fl_no_valid2", out_valid, 0);

    // Flush in IDLE blocks the request.
    req_valid = 1'b1; flush = 1'b1;
    #1;
    check("fl_idle_block", req_ready, 0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("fl_idle_not_acc", rf_cs, 0);

    // Flush in WB leaves the write intact.
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 64'h66;
    #1;
    tick();
    wb_valid = 1'b0; flush = 1'b1;
    #1;
    check("fl_wb_we", rf_we, 1);
    tick();
    flush = 1'b0;
    #1;
    check("fl_wb_mem", mem[6], 64'h66);
    fetch(5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 2, 0, 64'h66, 64'h0);

    // Asynchronous reset while holding operands.
    req_rs1 = 5'd5; req_use_rs1 = 1'b1; req_use_rs2 = 1'b0; req_rd = 5'd8;
    req_valid = 1'b1;
    #1;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    check("rh_valid_before", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rh_valid_async", out_valid, 0);
    check("rh_op1_async", out_op1, 0);
    #1 rst = 1'b0;
    #1;
    check("rh_cs", rf_cs, 0);
    check("rh_we", rf_we, 0);
    check("rh_addr", rf_addr, 0);
    check("rh_wdata", rf_wr_data, 0);
    check("rh_req_ready", req_ready, 1);
    tick();
    check("rh_idle_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
